multdiv_arbiter: RTL
====================

MULTDIV_ARBITER -- requirements
Module: multdiv_arbiter

Interface
REQ-001 Parameter TAG_W, 5: width of the requester-supplied tag.
REQ-002 Parameter TIMEOUT, 100: maximum cycles to wait for md_ready before forcing completion.
REQ-003 clock  input  1: single clock; all state changes on the rising edge.
REQ-004 reset_n  input  1: asynchronous, active-low reset.
REQ-005 req_valid[1:0]  input  2: per-requester request valid; held until granted.
REQ-006 req_op[1:0]  input  2: per-requester operation, 0=multiply, 1=divide.
REQ-007 req_a0, req_b0, req_a1, req_b1  input  32 each: signed operands for requesters 0 and 1.
REQ-008 req_tag0, req_tag1  input  TAG_W each: destination tags for requesters 0 and 1.
REQ-009 req_gnt[1:0]  output  2: one-cycle, one-hot grant; operands are sampled in the same cycle.
REQ-010 flush  input  1: kill the in-flight operation; its result is discarded.
REQ-011 md_operandA, md_operandB  output  32 each: operands to the shared multdiv unit, stable from the start pulse until completion.
REQ-012 md_ctrl_Mult, md_ctrl_Div  output  1 each: one-cycle start pulses, mutually exclusive.
REQ-013 md_result  input  32: multdiv result.
REQ-014 md_except  input  1: multdiv exception (e.g. divide by zero).
REQ-015 md_ready  input  1: multdiv completion pulse.
REQ-016 resp_valid  output  1: response available; held until resp_accept.
REQ-017 resp_result  output  32: captured result.
REQ-018 resp_except  output  1: captured exception, OR timeout.
REQ-019 resp_timeout  output  1: completion was forced by the timeout.
REQ-020 resp_tag  output  TAG_W: tag of the completed request.
REQ-021 resp_src  output  1: index of the completed requester.
REQ-022 resp_accept  input  1: consumer takes the response.

Function
REQ-023 The arbiter SHALL be an FSM with states IDLE, START, BUSY, HOLD and DRAIN.
REQ-024 IDLE: if any req_valid is set, grant exactly one requester, latch its op, operands, tag and index, and go to START.
REQ-025 Arbitration SHALL be round-robin: when both requesters are valid, grant the one not granted last; the pointer flips only on a grant.
REQ-026 START: assert md_ctrl_Mult or md_ctrl_Div for exactly one cycle, clear the timeout counter, and go to BUSY; md_ready is ignored in START.
REQ-027 BUSY, on md_ready: capture md_result and md_except, set resp_valid=1 and resp_timeout=0, and go to HOLD; the counter increments each cycle otherwise.
REQ-028 BUSY, when the counter reaches TIMEOUT-1 without md_ready: set resp_result=0, resp_except=1 and resp_timeout=1, and go to HOLD.
REQ-029 HOLD: hold resp_* stable; on resp_accept, clear resp_valid and go to IDLE; no grant is issued in HOLD.
REQ-030 flush in START or BUSY SHALL go to DRAIN with no response; DRAIN waits for md_ready or the timeout, then goes to IDLE with no response.
REQ-031 flush in HOLD SHALL clear resp_valid and go to IDLE; flush in IDLE or DRAIN SHALL have no effect.
REQ-032 flush has priority over a simultaneous md_ready or timeout in the same cycle.
REQ-033 The minimum request-to-response latency SHALL be grant cycle + 1 (START) + multdiv latency.
REQ-034 md_operandA and md_operandB SHALL hold the latched operands in START, BUSY and DRAIN, and be 0 otherwise.

Reset
REQ-035 While reset_n=0, the state SHALL be IDLE, all outputs 0, the counter 0, and the round-robin pointer favouring requester 0.
REQ-036 Assertion of reset mid-operation SHALL abandon the operation with no response; a late md_ready after reset is ignored in IDLE.

Verification
REQ-037 Req0 multiply 7 × -3 with tag 5 -> gnt=01, one md_ctrl_Mult pulse, then resp_result=-21, resp_except=0, resp_tag=5, resp_src=0.
REQ-038 Both requesters valid with back-to-back accepts -> grants alternate 01, 10, 01; there is never more than one op in flight.
REQ-039 Req1 divide 10 / 0 where the model raises md_except -> resp_except=1, resp_timeout=0, resp_src=1.
REQ-040 md_ready never asserted -> after TIMEOUT cycles in BUSY, resp_except=1, resp_timeout=1, resp_result=0.
REQ-041 flush in BUSY, then md_ready 3 cycles later -> no resp_valid; FSM in IDLE and the next grant is issued the cycle after.
REQ-042 resp_accept held low for 10 cycles with req_valid=11 -> resp_* stable and no grants until accept; reset_n pulsed in BUSY -> all outputs 0 immediately.

Source files
------------

// File: rtl/multdiv_arbiter.sv
// Two-requester round-robin front end for a shared multiply/divide unit.
// One operation is in flight at a time; the result is held for the consumer
// until it is accepted or flushed, and a stuck unit is released by a timeout.
//
// state | meaning
// IDLE  | waiting for a request; grant is issued combinationally here
// START | one-cycle start pulse to the multdiv unit, counter cleared
// BUSY  | waiting for md_ready or the timeout
// HOLD  | response presented, waiting for resp_accept (or flush)
// DRAIN | flushed op still running in the unit; wait it out, no response

module multdiv_arbiter #(
   parameter int TAG_W   = 5,
   parameter int TIMEOUT = 100
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [1:0]       req_valid,
   input  logic [1:0]       req_op,
   input  logic [31:0]      req_a0,
   input  logic [31:0]      req_b0,
   input  logic [31:0]      req_a1,
   input  logic [31:0]      req_b1,
   input  logic [TAG_W-1:0] req_tag0,
   input  logic [TAG_W-1:0] req_tag1,
   output logic [1:0]       req_gnt,
   input  logic             flush,
   output logic [31:0]      md_operandA,
   output logic [31:0]      md_operandB,
   output logic             md_ctrl_Mult,
   output logic             md_ctrl_Div,
   input  logic [31:0]      md_result,
   input  logic             md_except,
   input  logic             md_ready,
   output logic             resp_valid,
   output logic [31:0]      resp_result,
   output logic             resp_except,
   output logic             resp_timeout,
   output logic [TAG_W-1:0] resp_tag,
   output logic             resp_src,
   input  logic             resp_accept
);

   localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_BUSY,
      S_HOLD,
      S_DRAIN
   } state_t;

   state_t           r_state;
   logic             r_prio;        // 1: requester 1 wins a tie
   logic [31:0]      r_opa;
   logic [31:0]      r_opb;
   logic [TAG_W-1:0] r_tag;
   logic             r_src;
   logic [CNT_W-1:0] r_cnt;
   logic             r_mult;
   logic             r_div;
   logic             r_resp_valid;
   logic [31:0]      r_resp_result;
   logic             r_resp_except;
   logic             r_resp_timeout;
   logic [TAG_W-1:0] r_resp_tag;
   logic             r_resp_src;

   logic             w_pick1;
   logic [1:0]       w_gnt;
   logic             w_op;
   logic             w_last;
   logic             w_active;

   // Round-robin pick between the two requesters
   always_comb begin
      w_pick1 = req_valid[1] & (~req_valid[0] | r_prio);
      w_gnt   = 2'b00;
      if (req_valid != 2'b00) begin
         w_gnt = w_pick1 ? 2'b10 : 2'b01;
      end
      w_op = w_pick1 ? req_op[1] : req_op[0];
   end

   assign w_last   = (r_cnt == CNT_LAST);
   assign w_active = (r_state == S_START) || (r_state == S_BUSY) || (r_state == S_DRAIN);

   // Grant is gated by reset so nothing leaks out while reset_n is low
   assign req_gnt      = ((r_state == S_IDLE) && reset_n) ? w_gnt : 2'b00;
   assign md_operandA  = w_active ? r_opa : 32'd0;
   assign md_operandB  = w_active ? r_opb : 32'd0;
   assign md_ctrl_Mult = r_mult;
   assign md_ctrl_Div  = r_div;
   assign resp_valid   = r_resp_valid;
   assign resp_result  = r_resp_result;
   assign resp_except  = r_resp_except;
   assign resp_timeout = r_resp_timeout;
   assign resp_tag     = r_resp_tag;
   assign resp_src     = r_resp_src;

   // Main sequencing FSM with registered start pulses and response
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= S_IDLE;
         r_prio         <= 1'b0;
         r_opa          <= 32'd0;
         r_opb          <= 32'd0;
         r_tag          <= '0;
         r_src          <= 1'b0;
         r_cnt          <= '0;
         r_mult         <= 1'b0;
         r_div          <= 1'b0;
         r_resp_valid   <= 1'b0;
         r_resp_result  <= 32'd0;
         r_resp_except  <= 1'b0;
         r_resp_timeout <= 1'b0;
         r_resp_tag     <= '0;
         r_resp_src     <= 1'b0;
      end else begin
         r_mult <= 1'b0;
         r_div  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_gnt != 2'b00) begin
                  r_src   <= w_pick1;
                  r_prio  <= ~w_pick1;
                  r_opa   <= w_pick1 ? req_a1 : req_a0;
                  r_opb   <= w_pick1 ? req_b1 : req_b0;
                  r_tag   <= w_pick1 ? req_tag1 : req_tag0;
                  r_mult  <= ~w_op;
                  r_div   <= w_op;
                  r_state <= S_START;
               end
            end
            S_START: begin
               r_cnt   <= '0;
               r_state <= flush ? S_DRAIN : S_BUSY;
            end
            S_BUSY: begin
               if (flush) begin
                  // keep counting so DRAIN is bounded by the same timeout
                  r_cnt   <= w_last ? r_cnt : r_cnt + 1'b1;
                  r_state <= S_DRAIN;
               end else if (md_ready) begin
                  r_resp_valid   <= 1'b1;
                  r_resp_result  <= md_result;
                  r_resp_except  <= md_except;
                  r_resp_timeout <= 1'b0;
                  r_resp_tag     <= r_tag;
                  r_resp_src     <= r_src;
                  r_state        <= S_HOLD;
               end else if (w_last) begin
                  r_resp_valid   <= 1'b1;
                  r_resp_result  <= 32'd0;
                  r_resp_except  <= 1'b1;
                  r_resp_timeout <= 1'b1;
                  r_resp_tag     <= r_tag;
                  r_resp_src     <= r_src;
                  r_state        <= S_HOLD;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_HOLD: begin
               if (flush || resp_accept) begin
                  r_resp_valid <= 1'b0;
                  r_state      <= S_IDLE;
               end
            end
            S_DRAIN: begin
               if (md_ready || w_last) begin
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
